// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, valid/ready instruction-memory requests, in-order prefetch FIFO and decoder field split.
// Optional feature macro: FETCH_PERF_EN builds the fetched/flush performance counters (tied to zero otherwise).
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              dec_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [1:0]        op,
  output logic              funct5,
  output logic              funct4,
  output logic              funct1,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushes
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [CNT_W-1:0]  outstanding, outstanding_n;
  logic [CNT_W-1:0]  drop, drop_n;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  in_flight;
  logic [CNT_W:0]    occupancy;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [ADDR_W-1:0] resp_pc;
  logic              accept, rsp_ok, push, pop;

  // Only one of outstanding/drop is non-zero at a time: FETCH owns the former, FLUSH the latter.
  assign in_flight = outstanding + drop;
  assign occupancy = {1'b0, outstanding} + {1'b0, count};

  assign imem_req_valid = !reset && (state == FETCH) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  // A response with nothing in flight is a memory protocol error and is ignored.
  assign rsp_ok         = imem_rsp_valid && (in_flight != '0);
  assign push           = (state == FETCH) && rsp_ok && !redirect;
  assign pop            = instr_valid && dec_ready;

  // In-flight requests are contiguous words ending just below pc, so the oldest one is pc - 4*outstanding.
  assign resp_pc = pc - ADDR_W'({outstanding, 2'b00});

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_n       = state;
    pc_n          = pc;
    outstanding_n = outstanding;
    drop_n        = drop;
    if (redirect) begin
      pc_n          = {redirect_pc[ADDR_W-1:2], 2'b00};
      outstanding_n = '0;
      drop_n        = in_flight + CNT_W'(accept) - CNT_W'(rsp_ok);
      state_n       = (drop_n != '0) ? FLUSH : FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (accept) pc_n = pc + ADDR_W'(4);
          outstanding_n = outstanding + CNT_W'(accept) - CNT_W'(rsp_ok);
        end
        FLUSH: begin
          drop_n = drop - CNT_W'(rsp_ok);
          if (drop_n == '0) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      outstanding <= outstanding_n;
      drop        <= drop_n;
      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // NOTE: FIFO storage is not reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
  assign op          = instr[27:26];
  assign funct5      = instr[25];
  assign funct4      = instr[24];
  assign funct1      = instr[20];

  // The low address bits of a redirect target are architecturally ignored.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (pop)      perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`else
  assign perf_fetched = 32'h0;
  assign perf_flushes = 32'h0;
`endif

`ifndef SYNTHESIS
  rsp_protocol: assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> (in_flight != '0))
    else $error("imem response arrived with no request in flight");
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: decode table, directed corner sequences and a randomized run
// against a stream-level reference model (expected PC stream plus an in-order memory queue).
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_req_ready, imem_rsp_valid, redirect, dec_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req_valid, instr_valid, funct5, funct4, funct1;
  logic [31:0] imem_addr, instr, instr_pc, perf_fetched, perf_flushes;
  logic [1:0]  op;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .op(op), .funct5(funct5), .funct4(funct4), .funct1(funct1),
    .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
  );

  // Second instance exercising the top-of-address-space reset PC.
  logic        w_reset, w_req_ready, w_rsp_valid, w_dec_ready;
  logic [31:0] w_rdata;
  logic        w_req_valid, w_instr_valid, w_funct5, w_funct4, w_funct1;
  logic [31:0] w_addr, w_instr, w_instr_pc, w_perf_fetched, w_perf_flushes;
  logic [1:0]  w_op;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .reset(w_reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0), .dec_ready(w_dec_ready),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
    .op(w_op), .funct5(w_funct5), .funct4(w_funct4), .funct1(w_funct1),
    .perf_fetched(w_perf_fetched), .perf_flushes(w_perf_flushes)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] word;
    logic [4:0]  fields;   // {op, funct5, funct4, funct1}
  } dec_vec_t;

  int          vectors = 0, miscompares = 0;
  int          cycle = 0, since_rst = 0, first_valid = 0, acc_cnt = 0;
  int          lat_min = 1, lat_max = 1, rsp_pct = 100;
  bit          stale_in_reset = 1'b0, hold_pending = 1'b0;
  logic [31:0] hold_addr, exp_pc, req_exp, perf_pops, perf_flush;
  req_t        memq[$];
  logic [31:0] pop_pcs[$];
  logic [4:0]  pop_fields[$];
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock of the main DUT: drive at the falling edge, check settled outputs, model the coming rising edge.
  task automatic step(input bit rst, input bit rdy, input bit drdy, input bit redir, input logic [31:0] rpc);
    bit          give_rsp, acc, pp;
    logic [31:0] w;
    if (rst) memq.delete();
    give_rsp = rst ? stale_in_reset
                   : ((memq.size() > 0) && (memq[0].due <= cycle) && ($urandom_range(99) < rsp_pct));
    reset          = rst;
    imem_req_ready = rdy;
    dec_ready      = drdy;
    redirect       = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = give_rsp;
    imem_rdata     = (give_rsp && !rst) ? mem_word(memq[0].addr) : 32'hDEAD_BEEF;
    #1;
    if (rst) begin
      exp_pc = 32'h0; req_exp = 32'h0; perf_pops = 0; perf_flush = 0;
      hold_pending = 1'b0; since_rst = 0; first_valid = 0; acc_cnt = 0;
      pop_pcs.delete(); pop_fields.delete();
    end else begin
      since_rst++;
      if (instr_valid && first_valid == 0) first_valid = since_rst;
      if (hold_pending) begin
        check("req_hold_valid", imem_req_valid, 1);
        check("req_hold_addr", imem_addr, hold_addr);
      end
      acc = imem_req_valid && rdy;
      pp  = instr_valid && drdy;
      if (acc) begin
        check("req_addr", imem_addr, req_exp);
        req_exp += 4;
        memq.push_back('{addr: imem_addr, due: cycle + int'($urandom_range(lat_max, lat_min))});
        acc_cnt++;
      end
      if (pp) begin
        w = mem_word(exp_pc);
        check("instr_pc", instr_pc, exp_pc);
        check("instr", instr, w);
        check("fields", {op, funct5, funct4, funct1}, {w[27:26], w[25], w[24], w[20]});
        pop_pcs.push_back(instr_pc);
        pop_fields.push_back({op, funct5, funct4, funct1});
        exp_pc += 4;
        perf_pops++;
      end
      if (give_rsp) void'(memq.pop_front());
      hold_pending = imem_req_valid && !rdy && !redir;
      hold_addr    = imem_addr;
      if (redir) begin
        exp_pc  = {rpc[31:2], 2'b00};
        req_exp = exp_pc;
        perf_flush++;
      end
      check("inflight_bound", memq.size() <= DEPTH, 1);
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic run_until_pops(input string name, input int n, input int budget);
    int b;
    b = budget;
    while (pop_pcs.size() < n && b > 0) begin
      step(0, 1, 1, 0, 0);
      b--;
    end
    check(name, pop_pcs.size() >= n, 1);
  endtask

  task automatic check_perf(input string tag);
`ifdef FETCH_PERF_EN
    check({tag, "_perf_fetched"}, perf_fetched, perf_pops);
    check({tag, "_perf_flushes"}, perf_flushes, perf_flush);
`else
    check({tag, "_perf_fetched"}, perf_fetched, 0);
    check({tag, "_perf_flushes"}, perf_flushes, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_vec_t dvec [6];
    int       b;

    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    w_reset = 1'b1; w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rdata = '0; w_dec_ready = 1'b0;

    dvec[0] = '{32'hE591_2004, 5'b01_0_1_1};
    dvec[1] = '{32'h0C00_0000, 5'b11_0_0_0};
    dvec[2] = '{32'h0210_0000, 5'b00_1_0_1};
    dvec[3] = '{32'h0900_0000, 5'b10_0_1_0};
    dvec[4] = '{32'hFFFF_FFFF, 5'b11_1_1_1};
    dvec[5] = '{32'hF0EF_FFFF, 5'b00_0_0_0};
    mem_ovr[32'h8] = 32'hE591_2004;
    for (int i = 0; i < 6; i++) mem_ovr[32'h400 + 32'(4 * i)] = dvec[i].word;

    @(negedge clk);
    do_reset(3);

    // Reset state of the main instance.
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_fields", {op, funct5, funct4, funct1}, 0);
    check_perf("rst");

    // Straight-line fetch with a 1-cycle memory; word at 8 exercises the decoder fields.
    run_until_pops("t1_pops", 3, 30);
    check("t1_first_valid_cycle", first_valid, 3);
    check("t1_pc0", pop_pcs[0], 32'h0);
    check("t1_pc1", pop_pcs[1], 32'h4);
    check("t1_pc2", pop_pcs[2], 32'h8);
    check("t2_fields_at_8", pop_fields[2], 5'b01_0_1_1);
    check_perf("t1");

    // Decoder stall: exactly DEPTH requests, then request valid drops with nothing lost.
    do_reset(2);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    check("t3_accepts", acc_cnt, DEPTH);
    check("t3_req_valid_low", imem_req_valid, 0);
    check("t3_instr_valid", instr_valid, 1);
    run_until_pops("t3_pops", 3, 30);
    check("t3_pc0", pop_pcs[0], 32'h0);
    check("t3_pc1", pop_pcs[1], 32'h4);
    check("t3_pc2", pop_pcs[2], 32'h8);

    // Decode table applied through memory at 0x400.
    step(0, 1, 0, 1, 32'h400);
    pop_pcs.delete(); pop_fields.delete();
    run_until_pops("tbl_pops", 6, 60);
    for (int i = 0; i < 6; i++) check($sformatf("tbl_fields_%0d", i), pop_fields[i], dvec[i].fields);

    // 3-cycle memory, redirect with two requests in flight.
    do_reset(2);
    lat_min = 3; lat_max = 3;
    b = 20;
    while (memq.size() < 2 && b > 0) begin step(0, 1, 0, 0, 0); b--; end
    check("t4_two_outstanding", memq.size(), 2);
    pop_pcs.delete();
    step(0, 1, 1, 1, 32'h100);
    check("t4_flush_no_req", imem_req_valid, 0);
    check("t4_flush_no_instr", instr_valid, 0);
    run_until_pops("t4_pops", 1, 40);
    check("t4_first_pc", pop_pcs[0], 32'h100);

    // Redirect coinciding with a response and a pop, then a second redirect during FLUSH.
    do_reset(2);
    lat_min = 2; lat_max = 2;
    b = 30;
    while (!(instr_valid && memq.size() > 0 && memq[0].due <= cycle) && b > 0) begin
      step(0, 1, 0, 0, 0);
      b--;
    end
    check("t5_setup", b > 0, 1);
    step(0, 1, 1, 1, 32'h180);
    pop_pcs.delete();
    step(0, 1, 1, 1, 32'h203);
    run_until_pops("t5_pops", 1, 40);
    check("t5_first_pc", pop_pcs[0], 32'h200);
    check_perf("t5");

    // Reset mid-fetch with a stale response arriving while reset is held.
    do_reset(2);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    stale_in_reset = 1'b1;
    step(1, 1, 1, 0, 0);
    stale_in_reset = 1'b0;
    check("t6_rst_instr_valid", instr_valid, 0);
    check("t6_rst_instr", instr, 0);
    check("t6_rst_instr_pc", instr_pc, 0);
    check("t6_rst_req_valid", imem_req_valid, 0);
    check_perf("t6_rst");
    run_until_pops("t6_pops", 2, 30);
    check("t6_first_pc", pop_pcs[0], 32'h0);

    // Randomized traffic: variable ready, latency, stalls, redirects and occasional resets.
    lat_min = 1; lat_max = 4; rsp_pct = 70;
    do_reset(2);
    b = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      if ($urandom_range(599) == 0) begin
        do_reset(1 + $urandom_range(1));
      end else begin
        if (instr_valid) b++;
        step(0, $urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(39) == 0, tgt);
      end
    end
    check("rand_progress", b > 300, 1);
    check_perf("rand");

    // Top-of-memory reset PC: FFFFFFFC then wrap to 0.
    @(negedge clk);
    w_reset = 1'b0; w_req_ready = 1'b1; w_dec_ready = 1'b1;
    #1;
    check("wrap_req_valid", w_req_valid, 1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_rsp_valid = 1'b1; w_rdata = 32'h1111_1111;
    #1;
    check("wrap_addr1", w_addr, 32'h0);
    @(negedge clk);
    w_req_ready = 1'b0; w_rsp_valid = 1'b1; w_rdata = 32'h2222_2222;
    #1;
    check("wrap_instr_pc0", w_instr_pc, 32'hFFFF_FFFC);
    check("wrap_instr0", w_instr, 32'h1111_1111);
    @(negedge clk);
    w_rsp_valid = 1'b0;
    #1;
    check("wrap_instr_pc1", w_instr_pc, 32'h0);
    check("wrap_instr1", w_instr, 32'h2222_2222);
    check("wrap_next_addr", w_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
